reg_scoreboard_ctl: RTL and testbench

- Per-register pending-write scoreboard and ID-stage issue controller for the in-order pipeline.
- Tracks in-flight writers per architectural register instead of comparing ID against each later stage.
- Generates the ID stall and the issue fire, and sequences serializing instructions (fence/ecall) through a drain state machine.
- Sits beside the decode stage; fed by the ID decode fields and the WB retire port.

---
 rtl/reg_scoreboard_ctl.sv | 125 ++++++++++++
 tb/tb_reg_scoreboard_ctl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard_ctl.sv
// reg_scoreboard_ctl: per-register pending-write scoreboard and ID issue controller.
// Each architectural register r=1..31 has a small counter of in-flight writers.
// ID stalls on RAW against a pending writer, on writer-count saturation, or
// while a serializing instruction waits for the pipeline to drain.
// Optional build macro SCOREBOARD_STATS_EN adds a saturating stall_cycles counter.
module reg_scoreboard_ctl #(
  parameter int CNT_W        = 2,
  parameter int MAX_INFLIGHT = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        id_valid,
  input  logic [4:0]  id_rs1,
  input  logic        id_en_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_en_rs2,
  input  logic [4:0]  id_rd,
  input  logic        id_en_rd,
  input  logic        id_serialize,
  input  logic        ex_ready,
  input  logic        wb_retire,
  input  logic [4:0]  wb_rd,
  input  logic        wb_en_rd,
  output logic        stall_id,
  output logic        id_fire,
  output logic [31:0] busy_mask,
  output logic        drain_active
`ifdef SCOREBOARD_STATS_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  logic [31:0][CNT_W-1:0] cnt_q;
  logic [31:0][CNT_W-1:0] cnt_d;
  state_t                 state_q;
  state_t                 state_d;
  logic [31:0]            busy;
  logic                   raw_hz;
  logic                   sat_hz;
  logic                   ser_hz;
  logic                   any_busy;

  // Per-register next-count: simultaneous issue and retire cancel, underflow holds at zero.
  for (genvar gi = 0; gi < 32; gi++) begin : g_cnt
    if (gi == 0) begin : g_x0
      assign cnt_d[gi] = '0;
      assign busy[gi]  = 1'b0;
    end else begin : g_xr
      logic inc_w;
      logic dec_w;
      assign inc_w = id_fire && id_en_rd && (id_rd == 5'(gi));
      assign dec_w = wb_retire && wb_en_rd && (wb_rd == 5'(gi));
      assign cnt_d[gi] = (inc_w == dec_w)    ? cnt_q[gi] :
                         inc_w               ? cnt_q[gi] + CNT_W'(1) :
                         (cnt_q[gi] == '0)   ? cnt_q[gi] :
                                               cnt_q[gi] - CNT_W'(1);
      assign busy[gi] = (cnt_q[gi] != '0);
    end
  end

  assign any_busy = (busy != 32'd0);

  // Hazard detection and issue decision, purely from current state and ID fields.
  always_comb begin
    raw_hz = id_valid &&
             ((id_en_rs1 && (id_rs1 != 5'd0) && (cnt_q[id_rs1] != '0)) ||
              (id_en_rs2 && (id_rs2 != 5'd0) && (cnt_q[id_rs2] != '0)));
    sat_hz = id_valid && id_en_rd && (id_rd != 5'd0) &&
             (cnt_q[id_rd] == CNT_W'(MAX_INFLIGHT));
    ser_hz = id_valid && id_serialize && ((state_q == ST_DRAIN) || any_busy);
    stall_id = raw_hz || sat_hz || ser_hz;
    id_fire  = id_valid && !stall_id && ex_ready;
  end

  // Drain sequencing: enter when a serializer meets busy registers, leave once all are idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (id_valid && id_serialize && any_busy) state_d = ST_DRAIN;
      ST_DRAIN: if (!any_busy) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // Scoreboard counters and FSM state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      state_q <= ST_RUN;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign busy_mask    = busy;
  assign drain_active = (state_q == ST_DRAIN);

`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] stall_cycles_d;

  // Count cycles where a valid ID instruction is held, saturating at all-ones.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (id_valid && stall_id && (stall_cycles_q != 32'hFFFF_FFFF))
      stall_cycles_d = stall_cycles_q + 32'd1;
  end

  // Stall statistics register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_cycles_q <= 32'd0;
    else          stall_cycles_q <= stall_cycles_d;
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_reg_scoreboard_ctl.sv
// tb_reg_scoreboard_ctl: directed stimulus with a behavioural scoreboard model
// checked every cycle, plus hand-computed literal checks along the sequence.
module tb_reg_scoreboard_ctl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        id_valid;
  logic [4:0]  id_rs1;
  logic        id_en_rs1;
  logic [4:0]  id_rs2;
  logic        id_en_rs2;
  logic [4:0]  id_rd;
  logic        id_en_rd;
  logic        id_serialize;
  logic        ex_ready;
  logic        wb_retire;
  logic [4:0]  wb_rd;
  logic        wb_en_rd;
  logic        stall_id;
  logic        id_fire;
  logic [31:0] busy_mask;
  logic        drain_active;
`ifdef SCOREBOARD_STATS_EN
  logic [31:0] stall_cycles;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  // Behavioural model state
  int          mcnt [32];
  bit          mdrain;
  logic [31:0] mstall;

  localparam int MAXW = 3;

  reg_scoreboard_ctl #(.CNT_W(2), .MAX_INFLIGHT(MAXW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_en_rs1    (id_en_rs1),
    .id_rs2       (id_rs2),
    .id_en_rs2    (id_en_rs2),
    .id_rd        (id_rd),
    .id_en_rd     (id_en_rd),
    .id_serialize (id_serialize),
    .ex_ready     (ex_ready),
    .wb_retire    (wb_retire),
    .wb_rd        (wb_rd),
    .wb_en_rd     (wb_en_rd),
    .stall_id     (stall_id),
    .id_fire      (id_fire),
    .busy_mask    (busy_mask),
    .drain_active (drain_active)
`ifdef SCOREBOARD_STATS_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_busy();
    logic [31:0] b = 32'd0;
    for (int r = 1; r < 32; r++) b[r] = (mcnt[r] > 0);
    return b;
  endfunction

  function automatic logic m_stall();
    logic raw, sat, ser;
    raw = id_valid && ((id_en_rs1 && id_rs1 != 0 && mcnt[id_rs1] > 0) ||
                       (id_en_rs2 && id_rs2 != 0 && mcnt[id_rs2] > 0));
    sat = id_valid && id_en_rd && id_rd != 0 && mcnt[id_rd] == MAXW;
    ser = id_valid && id_serialize && (mdrain || m_busy() != 0);
    return raw || sat || ser;
  endfunction

  function automatic logic m_fire();
    return id_valid && !m_stall() && ex_ready;
  endfunction

  function automatic int m_next(input int r);
    int n = mcnt[r];
    bit inc = m_fire() && id_en_rd && (id_rd == 5'(r));
    bit dec = wb_retire && wb_en_rd && (wb_rd == 5'(r));
    if (inc && !dec) n = n + 1;
    if (dec && !inc && n > 0) n = n - 1;
    return n;
  endfunction

  // Model update at each clock edge; asynchronous clear on reset.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < 32; r++) mcnt[r] <= 0;
      mdrain <= 1'b0;
      mstall <= 32'd0;
    end else begin
      if (wb_retire && wb_en_rd && wb_rd != 0) begin
        n_chk++;
        if (mcnt[wb_rd] == 0 && !(m_fire() && id_en_rd && id_rd == wb_rd)) begin
          n_fail++;
          $display("FAIL retire_underflow: x%0d retired with 0 pending, required >0", wb_rd);
        end
      end
      for (int r = 1; r < 32; r++) mcnt[r] <= m_next(r);
      if (!mdrain) mdrain <= id_valid && id_serialize && (m_busy() != 0);
      else         mdrain <= (m_busy() != 0);
      if (id_valid && m_stall() && mstall != 32'hFFFF_FFFF) mstall <= mstall + 32'd1;
    end
  end

  // Per-cycle comparison of all outputs against the model, away from the active edge.
  always @(negedge clk) begin
    if (reset_n) begin
      chk("stall_id", {31'd0, stall_id}, {31'd0, m_stall()});
      chk("id_fire", {31'd0, id_fire}, {31'd0, m_fire()});
      chk("busy_mask", busy_mask, m_busy());
      chk("drain_active", {31'd0, drain_active}, {31'd0, mdrain});
`ifdef SCOREBOARD_STATS_EN
      chk("stall_cycles", stall_cycles, mstall);
`endif
    end
  end

  // One transaction per cycle: drive 1 time unit after the edge, settle, log.
  task automatic cyc(input bit v, input int rs1, input bit e1, input int rs2, input bit e2,
                     input int rd, input bit erd, input bit ser, input bit exr,
                     input bit ret, input int wrd, input bit wen);
    @(posedge clk);
    #1;
    id_valid = v; id_rs1 = 5'(rs1); id_en_rs1 = e1; id_rs2 = 5'(rs2); id_en_rs2 = e2;
    id_rd = 5'(rd); id_en_rd = erd; id_serialize = ser; ex_ready = exr;
    wb_retire = ret; wb_rd = 5'(wrd); wb_en_rd = wen;
    #1;
    $display("cyc t=%0t v=%b rs1=%0d rd=%0d ser=%b exr=%b ret=x%0d/%b | fire=%b stall=%b busy=%h drain=%b",
             $time, v, rs1, rd, ser, exr, wrd, ret, id_fire, stall_id, busy_mask, drain_active);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    id_valid = 0; id_rs1 = 0; id_en_rs1 = 0; id_rs2 = 0; id_en_rs2 = 0;
    id_rd = 0; id_en_rd = 0; id_serialize = 0; ex_ready = 0;
    wb_retire = 0; wb_rd = 0; wb_en_rd = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_stall", {31'd0, stall_id}, 32'd0);
    chk("rst_fire", {31'd0, id_fire}, 32'd0);
    chk("rst_busy", busy_mask, 32'd0);
    chk("rst_drain", {31'd0, drain_active}, 32'd0);
    @(posedge clk); #1 reset_n = 1'b1;
    idle();

    // RAW on x5, cleared one cycle after its retire
    cyc(1, 0, 0, 0, 0, 5, 1, 0, 1, 0, 0, 0); chk("x5_issue_fire", {31'd0, id_fire}, 32'd1);
    cyc(1, 5, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0); chk("x5_raw_stall", {31'd0, stall_id}, 32'd1);
    chk("x5_busy", busy_mask, 32'h20);
    cyc(1, 5, 1, 0, 0, 0, 0, 0, 1, 1, 5, 1); chk("x5_retire_cycle_stall", {31'd0, stall_id}, 32'd1);
    cyc(1, 5, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0); chk("x5_after_retire_stall", {31'd0, stall_id}, 32'd0);
    chk("x5_after_retire_fire", {31'd0, id_fire}, 32'd1);

    // Saturation on x7
    repeat (3) cyc(1, 0, 0, 0, 0, 7, 1, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 7, 1, 0, 1, 0, 0, 0); chk("x7_sat_stall", {31'd0, stall_id}, 32'd1);
    chk("x7_busy", busy_mask, 32'h80);
    cyc(1, 0, 0, 0, 0, 7, 1, 0, 1, 1, 7, 1); chk("x7_sat_retire_cycle", {31'd0, stall_id}, 32'd1);
    cyc(1, 0, 0, 0, 0, 7, 1, 0, 1, 0, 0, 0); chk("x7_4th_fire", {31'd0, id_fire}, 32'd1);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 1);
    idle(); chk("x7_drained", busy_mask, 32'd0);

    // Same-cycle issue and retire on x9
    cyc(1, 0, 0, 0, 0, 9, 1, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 9, 1, 0, 1, 1, 9, 1); chk("x9_same_cycle_fire", {31'd0, id_fire}, 32'd1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 1); chk("x9_cnt_held", busy_mask, 32'h200);
    idle(); chk("x9_cleared", busy_mask, 32'd0);

    // Serializing instruction drains x3,x4
    cyc(1, 0, 0, 0, 0, 3, 1, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 4, 1, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0); chk("ser_stall", {31'd0, stall_id}, 32'd1);
    chk("ser_busy", busy_mask, 32'h18);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 1); chk("ser_drain_novalid", {31'd0, drain_active}, 32'd1);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 4, 1); chk("ser_drain_x4", busy_mask, 32'h10);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0); chk("ser_empty_still_drain", {31'd0, drain_active}, 32'd1);
    chk("ser_empty_stall", {31'd0, stall_id}, 32'd1);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0); chk("ser_run_again", {31'd0, drain_active}, 32'd0);
    chk("ser_fire", {31'd0, id_fire}, 32'd1);

    // x0 never tracked; ex_ready low holds without stalling; idle serializer fires at once
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0); chk("x0_fire", {31'd0, id_fire}, 32'd1);
    cyc(1, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0); chk("x0_busy", busy_mask, 32'd0);
    chk("x0_read_stall", {31'd0, stall_id}, 32'd0);
    cyc(1, 0, 0, 0, 0, 6, 1, 0, 0, 0, 0, 0); chk("exr0_fire", {31'd0, id_fire}, 32'd0);
    chk("exr0_stall", {31'd0, stall_id}, 32'd0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0); chk("ser_idle_fire", {31'd0, id_fire}, 32'd1);
    idle(); chk("ser_idle_nodrain", {31'd0, drain_active}, 32'd0);

    // Asynchronous reset in the middle of a drain
    cyc(1, 0, 0, 0, 0, 2, 1, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 2, 1, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0); chk("pre_rst_drain", {31'd0, drain_active}, 32'd1);
    chk("pre_rst_busy", busy_mask, 32'h4);
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_busy", busy_mask, 32'd0);
    chk("async_rst_drain", {31'd0, drain_active}, 32'd0);
`ifdef SCOREBOARD_STATS_EN
    chk("async_rst_stats", stall_cycles, 32'd0);
`endif
    id_valid = 0; id_serialize = 0; ex_ready = 0;
    @(posedge clk); #1 reset_n = 1'b1;
    idle();
    idle(); chk("post_rst_busy", busy_mask, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
